// File: rtl/aes128_key_expander.sv
// AES-128 key expansion front end.
// Iterates one key-schedule round per clock, filling a round-key register
// file (rk[0..NR]) that the cipher datapath reads through a registered port.
module aes128_key_expander #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             key_ready,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key
);

    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t           state, state_next;
    logic [3:0]       counter;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] round_key;
    logic [KEY_W-1:0] rk [0:NR];

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i[2:0]]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed algebraically: inverse as x^254 (maps 0 to 0), then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for schedule round index (round-1).
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule round: derive round key `rnd` from the previous one.
    function automatic logic [KEY_W-1:0] schedule_round(input logic [3:0] rnd,
                                                        input logic [KEY_W-1:0] oldkey);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = oldkey[127:96];
        w1 = oldkey[95:64];
        w2 = oldkey[63:32];
        w3 = oldkey[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rcon(rnd - 4'd1), 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Combinational schedule stage fed by the counter and working key.
    always_comb begin
        round_key = schedule_round(counter, work);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXPAND;
            EXPAND:  if (counter == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Expansion datapath: counter, working key, register file and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b0;
            counter   <= '0;
            work      <= '0;
            for (int unsigned i = 0; i < NR + 1; i++) rk[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk[0]     <= key_in;
                        work      <= key_in;
                        counter   <= 4'd1;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[counter] <= round_key;
                    work        <= round_key;
                    if (counter == LAST) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_ready <= 1'b1;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered read port; indices beyond NR read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key <= '0;
        end else if (rd_round <= LAST) begin
            rd_key <= rk[rd_round];
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench for aes128_key_expander using a read-port scoreboard.
module tb_aes128_key_expander;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] fips_tab [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] zero_tab [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    aes128_key_expander #(.NR(10), .KEY_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_ready (key_ready),
        .rd_round  (rd_round),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status invariants sampled every cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (done && busy) begin
                errors++;
                $display("FAIL inv_done_busy: done=%0b busy=%0b, required not both 1", done, busy);
            end
            checks++;
            if (busy && key_ready) begin
                errors++;
                $display("FAIL inv_busy_ready: busy=%0b key_ready=%0b, required not both 1", busy, key_ready);
            end
        end
    end

    // Issue one read: push the expectation, pop and compare when rd_key is valid.
    task automatic read_check(input logic [3:0] idx, input logic [127:0] expv, input string name);
        logic [127:0] e;
        rd_round = idx;
        exp_q.push_back(expv);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rd_key !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, required %h", name, idx, rd_key, e);
        end
    endtask

    // Pulse start for one cycle at a negedge.
    task automatic pulse_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = $urandom();
    endtask

    // Start an expansion and check busy length, done pulse and key_ready.
    task automatic run_expansion(input logic [127:0] k, input string name);
        int cnt;
        pulse_start(k);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 10) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles, required 10", name, cnt);
        end
        checks++;
        if (done !== 1'b1 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%0b key_ready=%0b, required 1 1", name, done, key_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%0b one cycle later, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, key_ready} !== 3'b000 || rd_key !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b ready=%0b rd_key=%h, required all 0",
                     busy, done, key_ready, rd_key);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_check(4'd0, '0, "reset_rk");
    endtask

    task automatic test_fips_vector();
        run_expansion(FIPS_KEY, "fips");
        read_check(4'd1, fips_tab[1], "fips_rk");
        read_check(4'd10, fips_tab[10], "fips_rk");
        read_check(4'd0, FIPS_KEY, "fips_rk");
    endtask

    task automatic test_start_while_busy();
        int dones;
        int cnt;
        start  = 1'b1;
        key_in = FIPS_KEY;
        @(negedge clk);
        start  = 1'b0;
        dones  = 0;
        for (int c = 1; c < 20; c++) begin
            if (c == 4) begin
                start  = 1'b1;
                key_in = '1;
            end
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
        end
        cnt = dones;
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL busy_start_done_count: got %0d pulses, required 1", cnt);
        end
        read_check(4'd10, fips_tab[10], "busy_start_rk");
        read_check(4'd0, FIPS_KEY, "busy_start_rk");
    endtask

    task automatic test_out_of_range();
        read_check(4'd11, '0, "oor_rk");
        read_check(4'd15, '0, "oor_rk");
        read_check(4'd5, fips_tab[5], "oor_inrange_rk");
    endtask

    task automatic test_reset_mid_op();
        pulse_start(FIPS_KEY);
        rd_round = 4'd0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, key_ready} !== 3'b000 || rd_key !== '0) begin
            errors++;
            $display("FAIL midrst_async: busy=%0b done=%0b ready=%0b rd_key=%h, required all 0",
                     busy, done, key_ready, rd_key);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (key_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: key_ready=%0b busy=%0b, required 0 0", key_ready, busy);
        end
        read_check(4'd10, '0, "midrst_cleared_rk");
        run_expansion(SEQ_KEY, "seq");
        read_check(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "seq_rk");
        read_check(4'd0, SEQ_KEY, "seq_rk");
    endtask

    task automatic test_back_to_back();
        run_expansion(FIPS_KEY, "b2b_fips");
        for (int i = 0; i <= 10; i++) read_check(4'(i), fips_tab[i], "b2b_fips_rk");
        start  = 1'b1;
        key_in = '0;
        @(negedge clk);
        start  = 1'b0;
        checks++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_drop: key_ready=%0b busy=%0b, required 0 1", key_ready, busy);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_zero_ready: key_ready=%0b, required 1", key_ready);
        end
        for (int i = 0; i <= 10; i++) read_check(4'(i), zero_tab[i], "b2b_zero_rk");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rd_round = '0;
        test_reset();
        test_fips_vector();
        test_start_while_busy();
        test_out_of_range();
        test_reset_mid_op();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
